game_round_sequencer: RTL and testbench



---
 rtl/game_round_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_game_round_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_sequencer.sv
// Game-level sequencer for the whack-a-mole design.
// Steps through NUM_ROUNDS rounds, derives per-round difficulty from the
// current level, gates advancement on a per-round hit threshold and keeps a
// level-weighted, saturating total score.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for game_start
// CONFIG  | one cycle: pulse round_start, clear round_hits
// RUNNING | round engine active, hits are counted
// PAUSED  | round engine frozen, hits ignored
// EVAL    | one cycle: decide lose / win / next level
// WON     | terminal, all rounds passed; game_start restarts
// LOST    | terminal, a round missed the threshold; game_start restarts
module game_round_sequencer #(
  parameter int NUM_ROUNDS    = 3,
  parameter int PASS_HITS     = 2,
  parameter int TIME_W        = 27,
  parameter int MOLE_W        = 3,
  parameter int SCORE_W       = 8,
  parameter int HIT_W         = 4,
  parameter int BASE_INTERVAL = 12500000,
  parameter int INTERVAL_STEP = 2500000,
  parameter int MIN_INTERVAL  = 2500000,
  parameter int BASE_DURATION = 10000000,
  parameter int DURATION_STEP = 2500000,
  parameter int MIN_DURATION  = 2000000,
  parameter int BASE_MOLES    = 4,
  parameter int MOLE_STEP     = 2,
  parameter int MAX_MOLES     = 7,
  localparam int LVL_W        = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_start,
  input  logic              pause,
  input  logic              round_over,
  input  logic              hit_success,
  output logic              round_start,
  output logic              round_freeze,
  output logic [TIME_W-1:0] interval,
  output logic [TIME_W-1:0] duration,
  output logic [MOLE_W-1:0] molenum,
  output logic [LVL_W-1:0]  round_level,
  output logic [HIT_W-1:0]  round_hits,
  output logic [SCORE_W-1:0] total_score,
  output logic              game_over,
  output logic              game_won
);

  // Wide intermediates so level*step never wraps before the floor compare.
  localparam int CW = TIME_W + LVL_W;
  localparam int MW = MOLE_W + LVL_W;
  localparam int SW = SCORE_W + LVL_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_RUNNING, S_PAUSED, S_EVAL, S_WON, S_LOST
  } state_t;

  state_t state, state_nxt;

  logic               round_pass;
  logic               last_round;
  logic [HIT_W-1:0]   hits_inc;
  logic [SW-1:0]      score_sum;
  logic [SCORE_W-1:0] score_inc;
  logic [CW-1:0]      lvl_t;
  logic [CW-1:0]      int_dec;
  logic [CW-1:0]      dur_dec;
  logic [MW-1:0]      mole_sum;

  assign round_pass = int'(round_hits) >= PASS_HITS;
  assign last_round = int'(round_level) == (NUM_ROUNDS - 1);

  // Saturating increments for the hit counter and the weighted score.
  always_comb begin
    hits_inc  = (&round_hits) ? round_hits : round_hits + HIT_W'(1);
    score_sum = SW'(total_score) + SW'(round_level) + SW'(1);
    if (score_sum > SW'({SCORE_W{1'b1}}))
      score_inc = {SCORE_W{1'b1}};
    else
      score_inc = score_sum[SCORE_W-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; round_over wins over pause while a round is live.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (game_start) state_nxt = S_CONFIG;
      S_CONFIG:  state_nxt = S_RUNNING;
      S_RUNNING: begin
        if (round_over)  state_nxt = S_EVAL;
        else if (pause)  state_nxt = S_PAUSED;
      end
      S_PAUSED: begin
        if (round_over)  state_nxt = S_EVAL;
        else if (!pause) state_nxt = S_RUNNING;
      end
      S_EVAL: begin
        if (!round_pass)     state_nxt = S_LOST;
        else if (last_round) state_nxt = S_WON;
        else                 state_nxt = S_CONFIG;
      end
      S_WON, S_LOST: if (game_start) state_nxt = S_CONFIG;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    round_start  = 1'b0;
    round_freeze = 1'b0;
    game_over    = 1'b0;
    game_won     = 1'b0;
    case (state)
      S_CONFIG: round_start  = 1'b1;
      S_PAUSED: round_freeze = 1'b1;
      S_WON: begin
        game_over = 1'b1;
        game_won  = 1'b1;
      end
      S_LOST:   game_over    = 1'b1;
      default: ;
    endcase
  end

  // Level, per-round hits and total score.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_level <= '0;
      round_hits  <= '0;
      total_score <= '0;
    end else begin
      case (state)
        S_CONFIG: round_hits <= '0;
        S_RUNNING: begin
          if (hit_success) begin
            round_hits  <= hits_inc;
            total_score <= score_inc;
          end
        end
        S_EVAL: begin
          if (round_pass && !last_round)
            round_level <= round_level + LVL_W'(1);
        end
        S_WON, S_LOST: begin
          if (game_start) begin
            round_level <= '0;
            total_score <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Difficulty derived from the level: shrinking interval/duration with
  // floors, growing mole count with a ceiling.
  always_comb begin
    lvl_t    = CW'(round_level);
    int_dec  = lvl_t * CW'(INTERVAL_STEP);
    dur_dec  = lvl_t * CW'(DURATION_STEP);
    mole_sum = MW'(BASE_MOLES) + MW'(round_level) * MW'(MOLE_STEP);

    if ((int_dec > CW'(BASE_INTERVAL)) ||
        ((CW'(BASE_INTERVAL) - int_dec) < CW'(MIN_INTERVAL)))
      interval = TIME_W'(MIN_INTERVAL);
    else
      interval = TIME_W'(CW'(BASE_INTERVAL) - int_dec);

    if ((dur_dec > CW'(BASE_DURATION)) ||
        ((CW'(BASE_DURATION) - dur_dec) < CW'(MIN_DURATION)))
      duration = TIME_W'(MIN_DURATION);
    else
      duration = TIME_W'(CW'(BASE_DURATION) - dur_dec);

    if (mole_sum > MW'(MAX_MOLES))
      molenum = MOLE_W'(MAX_MOLES);
    else
      molenum = MOLE_W'(mole_sum);
  end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer: a default instance plus a SCORE_W=4
// instance driven by the same stimulus. Expected round configs are queued
// when a round is launched and checked when round_start appears.
module tb_game_round_sequencer;

  logic clk;
  logic rst;
  logic game_start;
  logic pause;
  logic round_over;
  logic hit_success;

  logic        round_start, round_freeze, game_over, game_won;
  logic [26:0] interval, duration;
  logic [2:0]  molenum;
  logic [1:0]  round_level;
  logic [3:0]  round_hits;
  logic [7:0]  total_score;

  logic        s4_round_start, s4_round_freeze, s4_game_over, s4_game_won;
  logic [26:0] s4_interval, s4_duration;
  logic [2:0]  s4_molenum;
  logic [1:0]  s4_round_level;
  logic [3:0]  s4_round_hits;
  logic [3:0]  s4_total_score;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int unsigned interval;
    int unsigned duration;
    int unsigned molenum;
    int unsigned level;
  } cfg_t;

  cfg_t cfg_q[$];

  game_round_sequencer u_dut (
    .clk(clk), .rst(rst), .game_start(game_start), .pause(pause),
    .round_over(round_over), .hit_success(hit_success),
    .round_start(round_start), .round_freeze(round_freeze),
    .interval(interval), .duration(duration), .molenum(molenum),
    .round_level(round_level), .round_hits(round_hits),
    .total_score(total_score), .game_over(game_over), .game_won(game_won)
  );

  game_round_sequencer #(.SCORE_W(4)) u_dut_s4 (
    .clk(clk), .rst(rst), .game_start(game_start), .pause(pause),
    .round_over(round_over), .hit_success(hit_success),
    .round_start(s4_round_start), .round_freeze(s4_round_freeze),
    .interval(s4_interval), .duration(s4_duration), .molenum(s4_molenum),
    .round_level(s4_round_level), .round_hits(s4_round_hits),
    .total_score(s4_total_score), .game_over(s4_game_over),
    .game_won(s4_game_won)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic cfg_t exp_cfg(input int l);
    cfg_t c;
    c.level = l;
    case (l)
      0:       begin c.interval = 12500000; c.duration = 10000000; c.molenum = 4; end
      1:       begin c.interval = 10000000; c.duration = 7500000;  c.molenum = 6; end
      default: begin c.interval = 7500000;  c.duration = 5000000;  c.molenum = 7; end
    endcase
    return c;
  endfunction

  // Every round_start must match a queued expectation.
  always @(negedge clk) begin
    cfg_t c;
    if (!rst && round_start) begin
      chk("start_pending", cfg_q.size(), 1);
      if (cfg_q.size() > 0) begin
        c = cfg_q.pop_front();
        chk("interval", 32'(interval), c.interval);
        chk("duration", 32'(duration), c.duration);
        chk("molenum", 32'(molenum), c.molenum);
        chk("cfg_level", 32'(round_level), c.level);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic start_game;
    cfg_q.push_back(exp_cfg(0));
    game_start = 1'b1;
    step;
    game_start = 1'b0;
    sample;
    chk("start_pulse", 32'(round_start), 1);
    chk("start_score", 32'(total_score), 0);
    chk("start_level", 32'(round_level), 0);
    step;
    chk("cfg_drained", cfg_q.size(), 0);
  endtask

  task automatic hits(input int n);
    hit_success = 1'b1;
    repeat (n) step;
    hit_success = 1'b0;
  endtask

  task automatic end_round(input bit next_round, input int next_level);
    if (next_round) cfg_q.push_back(exp_cfg(next_level));
    round_over = 1'b1;
    step;
    round_over = 1'b0;
    sample;
    chk("eval_no_start", 32'(round_start), 0);
    step;
    sample;
    chk("start_after_eval", 32'(round_start), 32'(next_round));
    if (next_round) begin
      step;
      chk("cfg_drained", cfg_q.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1; game_start = 1'b0; pause = 1'b0;
    round_over = 1'b0; hit_success = 1'b0;
    repeat (3) step;
    sample;
    chk("rst_level", 32'(round_level), 0);
    chk("rst_hits", 32'(round_hits), 0);
    chk("rst_score", 32'(total_score), 0);
    chk("rst_start", 32'(round_start), 0);
    chk("rst_freeze", 32'(round_freeze), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_won", 32'(game_won), 0);
    step;
    rst = 1'b0;
    step;

    // Full winning game: 2, 3, 2 hits -> 1*2 + 2*3 + 3*2 = 14.
    start_game;
    hits(2);
    sample;
    chk("r0_hits", 32'(round_hits), 2);
    chk("r0_score", 32'(total_score), 2);
    end_round(1'b1, 1);
    chk("r1_hits_clr", 32'(round_hits), 0);
    hits(3);
    sample;
    chk("r1_score", 32'(total_score), 8);
    end_round(1'b1, 2);
    hits(2);
    end_round(1'b0, 0);
    chk("win_over", 32'(game_over), 1);
    chk("win_won", 32'(game_won), 1);
    chk("win_level", 32'(round_level), 2);
    chk("win_score", 32'(total_score), 14);
    chk("win_hits_hold", 32'(round_hits), 2);

    // Restart, lose with a single hit, then restart again.
    start_game;
    hits(1);
    end_round(1'b0, 0);
    chk("lost_over", 32'(game_over), 1);
    chk("lost_won", 32'(game_won), 0);
    chk("lost_score", 32'(total_score), 1);
    chk("lost_level", 32'(round_level), 0);
    start_game;

    // Pause: hits ignored while frozen.
    pause = 1'b1;
    step;
    sample;
    chk("pause_freeze", 32'(round_freeze), 1);
    hits(3);
    sample;
    chk("pause_hits", 32'(round_hits), 0);
    chk("pause_score", 32'(total_score), 0);
    pause = 1'b0;
    step;
    sample;
    chk("resume_freeze", 32'(round_freeze), 0);
    hits(1);
    sample;
    chk("resume_hits", 32'(round_hits), 1);

    // Hit in the same cycle as round_over still counts and passes.
    cfg_q.push_back(exp_cfg(1));
    hit_success = 1'b1;
    round_over  = 1'b1;
    step;
    hit_success = 1'b0;
    round_over  = 1'b0;
    sample;
    chk("same_cycle_hits", 32'(round_hits), 2);
    chk("same_cycle_nostart", 32'(round_start), 0);
    step;
    sample;
    chk("same_cycle_start", 32'(round_start), 1);
    step;
    chk("cfg_drained", cfg_q.size(), 0);

    // Saturation: 20 hits at weight 2 on top of score 2.
    hits(20);
    sample;
    chk("sat_hits", 32'(round_hits), 15);
    chk("sat_score8", 32'(total_score), 42);
    chk("sat_score4", 32'(s4_total_score), 15);

    // Reset while RUNNING.
    rst = 1'b1;
    step;
    sample;
    chk("mid_rst_level", 32'(round_level), 0);
    chk("mid_rst_hits", 32'(round_hits), 0);
    chk("mid_rst_score", 32'(total_score), 0);
    chk("mid_rst_score4", 32'(s4_total_score), 0);
    chk("mid_rst_start", 32'(round_start), 0);
    chk("mid_rst_freeze", 32'(round_freeze), 0);
    chk("mid_rst_over", 32'(game_over), 0);
    chk("mid_rst_won", 32'(game_won), 0);
    rst = 1'b0;
    step;

    // game_start while RUNNING is ignored (no extra round_start expected).
    start_game;
    game_start = 1'b1;
    step;
    step;
    game_start = 1'b0;
    hits(1);
    sample;
    chk("ign_start_hits", 32'(round_hits), 1);
    chk("ign_start_over", 32'(game_over), 0);
    chk("ign_start_level", 32'(round_level), 0);

    step;
    chk("cfg_q_empty", cfg_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
